// File: rtl/sig_pkg.sv
// Shared lamp encodings, phase codes and default durations
// for the intersection phase scheduler.
package sig_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } lamp_t;

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5,
        WK  = 3'd6
    } phase_t;

    localparam int MIN_GREEN_D = 8;
    localparam int YELLOW_T_D  = 3;
    localparam int ALLRED_T_D  = 2;
    localparam int MAX_CNTRY_D = 16;
    localparam int WALK_T_D    = 6;
    localparam int CW_D        = 5;

endpackage

// File: rtl/sig_scheduler_if.sv
// Request inputs and lamp outputs of the scheduler.
// The scheduler takes the slave side, the environment the master side.
interface sig_scheduler_if;
    import sig_pkg::*;

    logic       car_x;
    logic       ped_req;
    lamp_t      hwy;
    lamp_t      cntry;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    modport master (
        output car_x, ped_req,
        input  hwy, cntry, walk, ped_ack, phase
    );

    modport slave (
        input  car_x, ped_req,
        output hwy, cntry, walk, ped_ack, phase
    );

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter that saturates at zero.
// tz flags an expired phase.
module phase_timer #(
    parameter int            CW      = 5,
    parameter logic [CW-1:0] RST_VAL = '0
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          tz
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (clear) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tz = (cnt == '0);

endmodule

// File: rtl/sig_scheduler.sv
// Counter-timed phase scheduler: highway, country road and
// pedestrian crossing share one intersection.
module sig_scheduler
    import sig_pkg::*;
#(
    parameter int MIN_GREEN = MIN_GREEN_D,
    parameter int YELLOW_T  = YELLOW_T_D,
    parameter int ALLRED_T  = ALLRED_T_D,
    parameter int MAX_CNTRY = MAX_CNTRY_D,
    parameter int WALK_T    = WALK_T_D,
    parameter int CW        = CW_D
) (
    input  logic          clock,
    input  logic          clear,
    sig_scheduler_if.slave bus
);

    logic [2:0]    state;
    logic [2:0]    nxt;
    logic          ped_pend;
    logic          tz;
    logic          load;
    logic          enter_wk;
    logic [CW-1:0] load_val;
    lamp_t         hwy_n;
    lamp_t         cntry_n;

    always_comb begin
        nxt = state;
        case (state)
            HG:  if (tz && (bus.car_x || ped_pend)) nxt = HY;
            HY:  if (tz) nxt = AR1;
            AR1: if (tz) nxt = ped_pend ? WK : CG;
            CG:  if (!bus.car_x || ped_pend || tz) nxt = CY;
            CY:  if (tz) nxt = AR2;
            AR2: if (tz) nxt = ped_pend ? WK : HG;
            WK:  if (tz) nxt = HG;
            default: nxt = HG;
        endcase
    end

    // Every state entry, including recovery from code 7, reloads the timer
    assign load     = (nxt != state);
    assign enter_wk = (nxt == WK) && (state != WK);

    always_comb begin
        load_val = CW'(MIN_GREEN - 1);
        case (nxt)
            HY, CY:   load_val = CW'(YELLOW_T - 1);
            AR1, AR2: load_val = CW'(ALLRED_T - 1);
            CG:       load_val = CW'(MAX_CNTRY - 1);
            WK:       load_val = CW'(WALK_T - 1);
            default:  load_val = CW'(MIN_GREEN - 1);
        endcase
    end

    always_comb begin
        hwy_n   = RED;
        cntry_n = RED;
        unique case (1'b1)
            nxt == HG: hwy_n   = GREEN;
            nxt == HY: hwy_n   = YELLOW;
            nxt == CG: cntry_n = GREEN;
            nxt == CY: cntry_n = YELLOW;
            default: ;
        endcase
    end

    phase_timer #(
        .CW      (CW),
        .RST_VAL (CW'(MIN_GREEN - 1))
    ) u_timer (
        .clock    (clock),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .tz       (tz)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= HG;
            ped_pend    <= 1'b0;
            bus.ped_ack <= 1'b0;
            bus.hwy     <= GREEN;
            bus.cntry   <= RED;
            bus.walk    <= 1'b0;
        end else begin
            state       <= nxt;
            ped_pend    <= enter_wk ? 1'b0 : (ped_pend | bus.ped_req);
            bus.ped_ack <= enter_wk;
            bus.hwy     <= hwy_n;
            bus.cntry   <= cntry_n;
            bus.walk    <= (nxt == WK);
        end
    end

    assign bus.phase = state;

endmodule

// File: tb/tb_sig_scheduler.sv
// Randomized and directed bench for sig_scheduler with a
// scoreboard fed by a phase/age reference model.
module tb_sig_scheduler;

    logic clock = 1'b0;
    logic clear = 1'b1;

    sig_scheduler_if bus();

    sig_scheduler dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ph;
        int hwy;
        int cntry;
        int walk;
        int ack;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int fails  = 0;

    // Phase lengths and lamp colours indexed by phase code
    int dur[7]     = '{8, 3, 2, 16, 3, 2, 6};
    int hwy_tab[7] = '{2, 1, 0, 0, 0, 0, 0};
    int cty_tab[7] = '{0, 0, 0, 2, 1, 0, 0};

    int m_ph   = 0;
    int m_age  = 0;
    bit m_pend = 1'b0;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, req, $time);
        end
    endtask

    function automatic void step(bit car, bit pr, bit clr);
        int nph;
        bit done;
        if (clr) begin
            m_ph   = 0;
            m_age  = 0;
            m_pend = 1'b0;
            return;
        end
        done = (m_age >= dur[m_ph] - 1);
        nph  = m_ph;
        case (m_ph)
            0: if (done && (car || m_pend)) nph = 1;
            1: if (done) nph = 2;
            2: if (done) nph = m_pend ? 6 : 3;
            3: if (!car || m_pend || done) nph = 4;
            4: if (done) nph = 5;
            5: if (done) nph = m_pend ? 6 : 0;
            6: if (done) nph = 0;
            default: nph = 0;
        endcase
        if (nph == 6 && m_ph != 6) m_pend = 1'b0;
        else if (pr) m_pend = 1'b1;
        m_age = (nph != m_ph) ? 0 : m_age + 1;
        m_ph  = nph;
    endfunction

    task automatic cyc(bit car, bit pr, bit clr);
        exp_t e;
        @(posedge clock);
        #1;
        bus.car_x   = car;
        bus.ped_req = pr;
        clear       = clr;
        e.ph    = m_ph;
        e.hwy   = hwy_tab[m_ph];
        e.cntry = cty_tab[m_ph];
        e.walk  = (m_ph == 6) ? 1 : 0;
        e.ack   = (m_ph == 6 && m_age == 0) ? 1 : 0;
        q.push_back(e);
        step(car, pr, clr);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("phase",   int'(bus.phase),   e.ph);
            chk("hwy",     int'(bus.hwy),     e.hwy);
            chk("cntry",   int'(bus.cntry),   e.cntry);
            chk("walk",    int'(bus.walk),    e.walk);
            chk("ped_ack", int'(bus.ped_ack), e.ack);
        end
    end

    initial begin
        bit car;
        int n;
        bus.car_x   = 1'b0;
        bus.ped_req = 1'b0;

        repeat (2) cyc(0, 0, 1);
        repeat (50) cyc(0, 0, 0);

        cyc(0, 0, 1);
        for (int i = 0; i < 40; i++) cyc(i >= 2 && i < 20, 0, 0);

        cyc(0, 0, 1);
        repeat (80) cyc(1, 0, 0);

        cyc(0, 0, 1);
        for (int i = 0; i < 30; i++) cyc(0, i == 3, 0);

        cyc(0, 0, 1);
        for (int i = 0; i < 50; i++) cyc(i >= 1, i == 1, 0);

        // Reset in the middle of a country green
        n = 0;
        while (bus.phase != 3'd3 && n < 100) begin
            cyc(1, 0, 0);
            n++;
        end
        chk("cg_reached", int'(bus.phase), 3);
        cyc(1, 0, 1);
        repeat (30) cyc(1, 0, 0);

        car = 1'b0;
        repeat (3000) begin
            if ($urandom_range(9) == 0) car = ~car;
            cyc(car, $urandom_range(24) == 0, $urandom_range(399) == 0);
        end
        cyc(0, 0, 0);

        @(negedge clock);
        @(negedge clock);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
